comp_result_monitor: RTL
========================

COMP_RESULT_MONITOR -- requirements
Module: comp_result_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of every counter output.
REQ-002 SHALL have parameter STREAK_TH, default 3: consecutive-equal count that raises streak_hit; legal range 1..2^CNT_W-1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clear  input  1  synchronous clear of all statistics.
REQ-006 SHALL have port in_valid  input  1  g/e/l carry a comparator result this cycle.
REQ-007 SHALL have port in_ready  output  1  monitor accepts a result this cycle.
REQ-008 SHALL have ports g, e, l  input  1 each  comparator flags (a>b, a==b, a<b).
REQ-009 SHALL have ports cnt_g, cnt_e, cnt_l  output  CNT_W each  accepted-result counts per class.
REQ-010 SHALL have port err_cnt  output  CNT_W  count of accepted non-one-hot results.
REQ-011 SHALL have port err  output  1  sticky flag: at least one non-one-hot result since reset/clear.
REQ-012 SHALL have port eq_streak  output  CNT_W  current run of consecutive accepted equal results.
REQ-013 SHALL have port streak_hit  output  1  high while FSM is in LOCK.

Function
REQ-014 in_ready SHALL equal !clear (combinational); a result is accepted at a rising edge where in_valid && in_ready.
REQ-015 Accepted result SHALL be valid iff exactly one of g, e, l is 1; zero-hot and multi-hot are invalid.
REQ-016 Valid accept SHALL increment exactly one of cnt_g/cnt_e/cnt_l; invalid accept SHALL increment err_cnt and set err, leaving class counters unchanged.
REQ-017 All counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-018 All outputs except in_ready SHALL be registered; effect of an accept visible immediately after the accepting edge (latency 1 cycle).
REQ-019 Cycles without an accept SHALL leave all state unchanged, including eq_streak (idle cycles do not break a run).
REQ-020 FSM states SHALL be IDLE, EQ_RUN, LOCK; reset/clear state IDLE.
REQ-021 IDLE: valid e -> eq_streak=1, go EQ_RUN, or LOCK directly if STREAK_TH==1; g or l -> stay, eq_streak=0.
REQ-022 EQ_RUN: valid e -> eq_streak+1, go LOCK when new value equals STREAK_TH, else stay; g or l -> IDLE, eq_streak=0.
REQ-023 LOCK: valid e -> stay, eq_streak+1 (saturating); g or l -> IDLE, eq_streak=0.
REQ-024 Invalid accept in any state SHALL force IDLE and eq_streak=0.
REQ-025 streak_hit SHALL be 1 exactly when state is LOCK.
REQ-026 clear SHALL take priority over any accept: at that edge all counters=0, err=0, eq_streak=0, state IDLE; concurrent in_valid result is dropped (in_ready=0).

Reset
REQ-027 rst_n low SHALL asynchronously force cnt_g=cnt_e=cnt_l=err_cnt=eq_streak=0, err=0, streak_hit=0, state IDLE, independent of clk.
REQ-028 During reset in_ready SHALL still follow !clear; no accept takes effect until first rising edge after rst_n deasserts.
REQ-029 Reset asserted mid-run (e.g. in LOCK) SHALL clear everything immediately; no partial update at the next edge.

Verification (CNT_W=8, STREAK_TH=3)
REQ-030 Accept g, l, e, e, e (in_valid=1 each cycle) -> cnt_g=1, cnt_l=1, cnt_e=3, eq_streak=3, streak_hit rises after 5th edge.
REQ-031 Accept e, e, idle 4 cycles (in_valid=0), e -> eq_streak 1,2,2,2,2,2,3; streak_hit=1 after last edge; then accept g -> eq_streak=0, streak_hit=0.
REQ-032 Accept {g,e,l}=110 then 000 -> err_cnt=2, err=1, class counters unchanged, state IDLE; next valid g -> cnt_g=1, err stays 1.
REQ-033 Accept 300 consecutive e -> cnt_e=255 and eq_streak=255 (saturated), streak_hit=1 throughout from 3rd accept.
REQ-034 In LOCK with cnt_e=5, assert clear with in_valid=1, e=1 -> in_ready=0, all outputs 0 after edge, result not counted.
REQ-035 In EQ_RUN with eq_streak=2, drop rst_n between clock edges -> all outputs 0 before next edge; after release, accept e -> eq_streak=1, streak_hit=0.

Source files
------------

// File: rtl/comp_result_monitor_if.sv
// +----------------------------------------------------------------------------+
// | Module : comp_result_monitor_if                                            |
// | Brief  : Comparator-result handshake and statistics bundle for the monitor |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface comp_result_monitor_if #(
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic             g;
   logic             e;
   logic             l;
   logic [CNT_W-1:0] cnt_g;
   logic [CNT_W-1:0] cnt_e;
   logic [CNT_W-1:0] cnt_l;
   logic [CNT_W-1:0] err_cnt;
   logic             err;
   logic [CNT_W-1:0] eq_streak;
   logic             streak_hit;

   modport master (
      output in_valid, g, e, l,
      input  in_ready, cnt_g, cnt_e, cnt_l, err_cnt, err, eq_streak, streak_hit
   );

   modport slave (
      input  in_valid, g, e, l,
      output in_ready, cnt_g, cnt_e, cnt_l, err_cnt, err, eq_streak, streak_hit
   );
endinterface

`default_nettype wire

// File: rtl/comp_result_monitor.sv
// +----------------------------------------------------------------------------+
// | Module : comp_result_monitor                                               |
// | Brief  : Counts comparator results per class, flags non-one-hot results    |
// |          and tracks runs of consecutive equal results.                     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module comp_result_monitor #(
   parameter int CNT_W     = 8,
   parameter int STREAK_TH = 3
) (
   input  wire                  clk,
   input  wire                  rst_n,
   input  wire                  clear,
   comp_result_monitor_if.slave mon
);

   localparam logic [CNT_W-1:0] c_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_TH  = CNT_W'(STREAK_TH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EQ_RUN = 2'd1,
      LOCK   = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt_g;
   logic [CNT_W-1:0] r_cnt_e;
   logic [CNT_W-1:0] r_cnt_l;
   logic [CNT_W-1:0] r_err_cnt;
   logic             r_err;
   logic [CNT_W-1:0] r_eq_streak;
   logic             r_streak_hit;

   logic             w_accept;
   logic             w_onehot;
   logic [CNT_W-1:0] w_streak_inc;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == c_MAX) ? v : v + 1'b1;
   endfunction

   assign mon.in_ready = !clear;
   assign w_accept     = mon.in_valid && !clear;
   assign w_onehot     = ({mon.g, mon.e, mon.l} == 3'b100) ||
                         ({mon.g, mon.e, mon.l} == 3'b010) ||
                         ({mon.g, mon.e, mon.l} == 3'b001);
   assign w_streak_inc = sat_inc(r_eq_streak);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_cnt_g      <= '0;
         r_cnt_e      <= '0;
         r_cnt_l      <= '0;
         r_err_cnt    <= '0;
         r_err        <= 1'b0;
         r_eq_streak  <= '0;
         r_streak_hit <= 1'b0;
      end else if (clear) begin
         r_state      <= IDLE;
         r_cnt_g      <= '0;
         r_cnt_e      <= '0;
         r_cnt_l      <= '0;
         r_err_cnt    <= '0;
         r_err        <= 1'b0;
         r_eq_streak  <= '0;
         r_streak_hit <= 1'b0;
      end else if (w_accept) begin
         if (!w_onehot) begin
            r_err_cnt    <= sat_inc(r_err_cnt);
            r_err        <= 1'b1;
            r_state      <= IDLE;
            r_eq_streak  <= '0;
            r_streak_hit <= 1'b0;
         end else if (!mon.e) begin
            if (mon.g) r_cnt_g <= sat_inc(r_cnt_g);
            else       r_cnt_l <= sat_inc(r_cnt_l);
            r_state      <= IDLE;
            r_eq_streak  <= '0;
            r_streak_hit <= 1'b0;
         end else begin
            r_cnt_e     <= sat_inc(r_cnt_e);
            r_eq_streak <= w_streak_inc;
            // Streak_hit is set alongside the LOCK transition so it stays registered.
            case (r_state)
               IDLE: begin
                  if (STREAK_TH == 1) begin
                     r_state      <= LOCK;
                     r_streak_hit <= 1'b1;
                  end else begin
                     r_state      <= EQ_RUN;
                     r_streak_hit <= 1'b0;
                  end
               end
               EQ_RUN: begin
                  if (w_streak_inc == c_TH) begin
                     r_state      <= LOCK;
                     r_streak_hit <= 1'b1;
                  end else begin
                     r_state      <= EQ_RUN;
                     r_streak_hit <= 1'b0;
                  end
               end
               LOCK: begin
                  r_state      <= LOCK;
                  r_streak_hit <= 1'b1;
               end
               default: begin
                  r_state      <= IDLE;
                  r_eq_streak  <= '0;
                  r_streak_hit <= 1'b0;
               end
            endcase
         end
      end
   end

   assign mon.cnt_g      = r_cnt_g;
   assign mon.cnt_e      = r_cnt_e;
   assign mon.cnt_l      = r_cnt_l;
   assign mon.err_cnt    = r_err_cnt;
   assign mon.err        = r_err;
   assign mon.eq_streak  = r_eq_streak;
   assign mon.streak_hit = r_streak_hit;

endmodule

`default_nettype wire
